q_6_24_seq_chk: RTL and testbench



---
 rtl/q_6_24_pkg.sv | 19 +
 rtl/q_6_24_nxt.sv | 25 ++
 rtl/q_6_24_seq_chk.sv | 118 +++++++++++
 tb/tb_q_6_24_seq_chk.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/q_6_24_pkg.sv
// Shared types and constants for the six-state sequence counter family.
// Codes follow 0->1->3->7->6->4->0; 2 and 5 never appear in a healthy stream.
package q_6_24_pkg;

    typedef logic [2:0] code_t;

    localparam code_t S0 = 3'd0;
    localparam code_t S1 = 3'd1;
    localparam code_t S2 = 3'd3;
    localparam code_t S3 = 3'd7;
    localparam code_t S4 = 3'd6;
    localparam code_t S5 = 3'd4;

    typedef enum logic [0:0] {
        StHunt = 1'b0,
        StLock = 1'b1
    } chk_state_e;

endpackage

// File: rtl/q_6_24_nxt.sv
// Successor map for the six-state sequence: returns nxt(code) and a legal flag.
// Illegal codes (2, 5) map to S0 so a generator built on this self-recovers.
module q_6_24_nxt
    import q_6_24_pkg::*;
(
    input  code_t code_i,
    output code_t nxt_o,
    output logic  legal_o
);

    always_comb begin
        nxt_o   = S0;
        legal_o = 1'b1;
        unique case (code_i)
            S0:      nxt_o = S1;
            S1:      nxt_o = S2;
            S2:      nxt_o = S3;
            S3:      nxt_o = S4;
            S4:      nxt_o = S5;
            S5:      nxt_o = S0;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/q_6_24_seq_chk.sv
// Receive-side lock/error checker for the six-state sequence counter.
// Define SEQ_CHK_ILLEGAL_EN to add the illegal_o pulse output for codes 2 and 5.
module q_6_24_seq_chk
    import q_6_24_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             sample_en_i,
    input  logic [2:0]       count_in_i,
    output logic             locked_o,
    output logic             seq_err_o,
    output logic [ERR_W-1:0] err_cnt_o,
`ifdef SEQ_CHK_ILLEGAL_EN
    output logic             illegal_o,
`endif
    output logic [2:0]       exp_next_o
);

    localparam int unsigned RunW = $clog2(LOCK_CNT + 1);
    localparam logic [RunW-1:0] LockTarget = RunW'(LOCK_CNT);

    chk_state_e       state_q;
    code_t            prev_q;
    logic             prev_vld_q;
    logic [RunW-1:0]  run_cnt_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic             seq_err_q;
    code_t            exp_next_q;

    code_t           nxt_prev;
    code_t           nxt_in;
    logic            legal_in;
    logic            unused_legal_prev;
    logic            good;
    logic [RunW-1:0] run_inc;

    q_6_24_nxt u_nxt_prev (
        .code_i  (prev_q),
        .nxt_o   (nxt_prev),
        .legal_o (unused_legal_prev)
    );

    // Second instance precomputes the expectation for the sample being taken.
    q_6_24_nxt u_nxt_in (
        .code_i  (count_in_i),
        .nxt_o   (nxt_in),
        .legal_o (legal_in)
    );

    assign good    = prev_vld_q && legal_in && (count_in_i == nxt_prev);
    assign run_inc = run_cnt_q + 1'b1;

`ifdef SEQ_CHK_ILLEGAL_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= sample_en_i && !legal_in;
        end
    end

    assign illegal_o = illegal_q;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= StHunt;
            prev_q     <= S0;
            prev_vld_q <= 1'b0;
            run_cnt_q  <= '0;
            err_cnt_q  <= '0;
            seq_err_q  <= 1'b0;
            exp_next_q <= S0;
        end else begin
            seq_err_q <= 1'b0;
            if (sample_en_i) begin
                // Bad samples are still loaded so reacquisition starts from them.
                prev_q     <= count_in_i;
                prev_vld_q <= 1'b1;
                exp_next_q <= nxt_in;
                unique case (state_q)
                    StHunt: begin
                        if (!good) begin
                            run_cnt_q <= '0;
                        end else if (run_inc == LockTarget) begin
                            state_q   <= StLock;
                            run_cnt_q <= '0;
                        end else begin
                            run_cnt_q <= run_inc;
                        end
                    end
                    StLock: begin
                        if (!good) begin
                            seq_err_q <= 1'b1;
                            state_q   <= StHunt;
                            run_cnt_q <= '0;
                            if (err_cnt_q != '1) begin
                                err_cnt_q <= err_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end
        end
    end

    assign locked_o   = (state_q == StLock);
    assign seq_err_o  = seq_err_q;
    assign err_cnt_o  = err_cnt_q;
    assign exp_next_o = exp_next_q;

endmodule

// File: tb/tb_q_6_24_seq_chk.sv
// Scoreboard bench for q_6_24_seq_chk (LOCK_CNT=3, ERR_W=2 to reach saturation quickly).
module tb_q_6_24_seq_chk;

    localparam int unsigned LockCnt = 3;
    localparam int unsigned ErrW    = 2;

    logic            clk = 1'b0;
    logic            rstb = 1'b0;
    logic            sample_en = 1'b0;
    logic [2:0]      count_in = 3'd0;
    logic            locked;
    logic            seq_err;
    logic [ErrW-1:0] err_cnt;
    logic [2:0]      exp_next;
`ifdef SEQ_CHK_ILLEGAL_EN
    logic            illegal;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            locked;
        logic            seq_err;
        logic [ErrW-1:0] err_cnt;
        logic [2:0]      exp_next;
        logic            illegal;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic [2:0]      m_prev;
    logic            m_vld;
    logic            m_locked;
    int              m_run;
    logic [ErrW-1:0] m_err;

    q_6_24_seq_chk #(
        .LOCK_CNT (LockCnt),
        .ERR_W    (ErrW)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .sample_en_i (sample_en),
        .count_in_i  (count_in),
        .locked_o    (locked),
        .seq_err_o   (seq_err),
        .err_cnt_o   (err_cnt),
`ifdef SEQ_CHK_ILLEGAL_EN
        .illegal_o   (illegal),
`endif
        .exp_next_o  (exp_next)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [2:0] ref_nxt(input logic [2:0] c);
        case (c)
            3'd0: return 3'd1;
            3'd1: return 3'd3;
            3'd3: return 3'd7;
            3'd7: return 3'd6;
            3'd6: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic ref_legal(input logic [2:0] c);
        return !(c == 3'd2 || c == 3'd5);
    endfunction

    task automatic model_reset();
        m_prev   = 3'd0;
        m_vld    = 1'b0;
        m_locked = 1'b0;
        m_run    = 0;
        m_err    = '0;
    endtask

    // One clock: drive at negedge, push model prediction, compare #1 after posedge.
    task automatic step(input logic en, input logic [2:0] v);
        exp_t e;
        logic good;
        exp_t got;
        @(negedge clk);
        sample_en = en;
        count_in  = v;
        e.seq_err = 1'b0;
        e.illegal = en && !ref_legal(v);
        if (en) begin
            good = m_vld && ref_legal(v) && (v == ref_nxt(m_prev));
            if (!m_locked) begin
                if (good) begin
                    m_run++;
                    if (m_run == LockCnt) begin
                        m_locked = 1'b1;
                        m_run    = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else if (!good) begin
                e.seq_err = 1'b1;
                m_locked  = 1'b0;
                m_run     = 0;
                if (m_err != '1) m_err = m_err + 1'b1;
            end
            m_prev = v;
            m_vld  = 1'b1;
        end
        e.locked   = m_locked;
        e.err_cnt  = m_err;
        e.exp_next = m_vld ? ref_nxt(m_prev) : 3'd0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("locked", 32'(locked), 32'(got.locked));
        check("seq_err", 32'(seq_err), 32'(got.seq_err));
        check("err_cnt", 32'(err_cnt), 32'(got.err_cnt));
        check("exp_next", 32'(exp_next), 32'(got.exp_next));
`ifdef SEQ_CHK_ILLEGAL_EN
        check("illegal", 32'(illegal), 32'(got.illegal));
`endif
    endtask

    task automatic seq(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                       input logic [2:0] d);
        step(1'b1, a);
        step(1'b1, b);
        step(1'b1, c);
        step(1'b1, d);
    endtask

    initial begin
        logic [2:0] lock_run [6];
        lock_run = '{3'd0, 3'd1, 3'd3, 3'd7, 3'd6, 3'd4};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_seq_err", 32'(seq_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_exp_next", 32'(exp_next), 32'd0);
`ifdef SEQ_CHK_ILLEGAL_EN
        check("rst_illegal", 32'(illegal), 32'd0);
`endif
        @(negedge clk);
        rstb = 1'b1;

        // Acquire lock on 0,1,3,7; locked after the edge sampling 7
        seq(3'd0, 3'd1, 3'd3, 3'd7);
        check("lock_min", 32'(locked), 32'd1);

        // Break: expected 4 but got 3; relock from the bad value
        step(1'b1, 3'd6);
        step(1'b1, 3'd3);
        check("break_exp_next", 32'(exp_next), 32'd7);
        step(1'b1, 3'd7);
        step(1'b1, 3'd6);
        step(1'b1, 3'd4);

        // Locked stream with enable gaps of 1..5 cycles
        for (int i = 0; i < 6; i++) begin
            for (int g = 0; g < (i % 5) + 1; g++) step(1'b0, 3'($urandom_range(7)));
            step(1'b1, lock_run[i]);
        end

        // Illegal code while locked, then relock through nxt(5)=0
        step(1'b1, 3'd5);
        seq(3'd0, 3'd1, 3'd3, 3'd7);

        // Async reset between edges while locked with err_cnt=2
        #2;
        rstb = 1'b0;
        sample_en = 1'b0;
        #1;
        model_reset();
        check("async_locked", 32'(locked), 32'd0);
        check("async_err_cnt", 32'(err_cnt), 32'd0);
        check("async_exp_next", 32'(exp_next), 32'd0);
        @(negedge clk);
        rstb = 1'b1;

        // First sample after release is not compared; illegal code in hunt clears run
        step(1'b1, 3'd6);
        step(1'b1, 3'd4);
        step(1'b1, 3'd2);
        step(1'b1, 3'd1);
        check("hunt_no_err", 32'(err_cnt), 32'd0);

        // Five lock/break cycles: err_cnt 1,2,3,3,3 with ERR_W=2
        for (int k = 0; k < 5; k++) begin
            seq(3'd0, 3'd1, 3'd3, 3'd7);
            step(1'b1, 3'd0);
            check("sat_pulse", 32'(seq_err), 32'd1);
            check("sat_cnt", 32'(err_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
